ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, RAM word-address width (1024 words).
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset; asynchronous, active-low.
REQ-004 a_req / b_req  input  1  requester A (fetch) / B (load-store) access request.
REQ-005 a_we / b_we  input  1  1 = write, 0 = read; qualified by req.
REQ-006 a_addr / b_addr  input  ADDR_W  word address.
REQ-007 a_wdata / b_wdata  input  32  write data.
REQ-008 a_gnt / b_gnt  output  1  one-cycle pulse: request accepted this cycle.
REQ-009 a_rvalid / b_rvalid  output  1  one-cycle pulse: access completed.
REQ-010 a_rdata / b_rdata  output  32  read data, valid only with rvalid.
REQ-011 ram_we  output  1  RAM write enable.
REQ-012 ram_re  output  1  RAM read enable.
REQ-013 ram_addr  output  ADDR_W  RAM address.
REQ-014 ram_wdata  output  32  RAM write data.
REQ-015 ram_rdata  input  32  RAM combinational read data.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-017 IDLE: any req -> gnt pulse same cycle (combinational from state and req), latch owner/we/addr/wdata, next ACCESS; no req -> stay IDLE.
REQ-018 ACCESS: exactly one cycle; ram_addr/ram_wdata from latched regs; ram_we = latched we; ram_re = !latched we; read data captured into rdata register at end of cycle; next RESP.
REQ-019 RESP: owner rvalid high one cycle, owner rdata = captured data for reads, 0 for writes; same-cycle arbitration as IDLE (gnt allowed), next ACCESS if granted else IDLE.
REQ-020 Latency: gnt at cycle T, RAM access T+1, rvalid T+2; sustained throughput one access per 2 cycles.
REQ-021 Round-robin: last_owner register; both reqs in a granting cycle -> grant the requester not equal to last_owner; single req -> grant it; last_owner updates on every gnt.
REQ-022 Never both gnt high in one cycle; never both rvalid high in one cycle.
REQ-023 gnt never asserts in ACCESS; reqs during ACCESS wait.
REQ-024 Requester holds req/we/addr/wdata stable until gnt; values after gnt are ignored; req may drop before gnt without side effect.
REQ-025 Outside ACCESS: ram_we = 0, ram_re = 0, ram_addr = 0, ram_wdata = 0.
REQ-026 Non-owner rvalid = 0 and rdata = 0; owner rdata = 0 whenever rvalid = 0.
REQ-027 Full address range 0 .. 2^ADDR_W-1 passes unmodified; no wrap or offset arithmetic.

Reset
REQ-028 RST_N low -> immediately state IDLE, last_owner = B (A wins first tie), latched regs and rdata register = 0.
REQ-029 During reset all outputs 0: gnt, rvalid, rdata, ram_we, ram_re, ram_addr, ram_wdata.
REQ-030 Reset during ACCESS aborts the access: ram_we drops asynchronously, no rvalid issued after release.
REQ-031 First grant possible in the first rising edge cycle with RST_N high.

Verification
REQ-032 A write addr 5 data 0xDEADBEEF, then A read addr 5 -> write: ram_we high one cycle at T+1; read: a_rvalid at T+2 with a_rdata 0xDEADBEEF.
REQ-033 a_req and b_req high same cycle after reset -> A granted first, B granted in RESP cycle of A; next tie grants A (last_owner = B).
REQ-034 Both reqs held high for 8 grants -> grants alternate A,B,A,B...; no cycle with both gnt or both rvalid high.
REQ-035 B read addr 1023 (max, ADDR_W 10) -> ram_addr = 1023 in ACCESS, b_rvalid at T+2 with RAM content.
REQ-036 RST_N low during ACCESS of B write -> ram_we drops immediately, RAM not written at next edge, b_rvalid never pulses; post-release tie grants A.
REQ-037 req asserted during ACCESS -> no gnt until RESP cycle; gnt and previous rvalid coincide in that cycle.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with combinational read data.
// Each access takes a grant cycle, one RAM cycle and one response cycle.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [31:0]       a_rdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              last_owner_q;  // 1 = B, so A wins the first tie after reset
  logic              owner_q;       // 1 = B
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic can_grant, gnt_a, gnt_b, granted, in_access, in_resp;

  // Grants are gated by RST_N so nothing is granted while reset is asserted.
  always_comb begin
    can_grant = RST_N && (state_q != StAccess);
    gnt_a     = can_grant && a_req && (!b_req || last_owner_q);
    gnt_b     = can_grant && b_req && (!a_req || !last_owner_q);
    granted   = gnt_a || gnt_b;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (granted) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = granted ? StAccess : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (granted) begin
        last_owner_q <= gnt_b;
        owner_q      <= gnt_b;
        we_q         <= gnt_b ? b_we    : a_we;
        addr_q       <= gnt_b ? b_addr  : a_addr;
        wdata_q      <= gnt_b ? b_wdata : a_wdata;
      end
      // Writes return zero data in the response cycle.
      if (state_q == StAccess) rdata_q <= we_q ? 32'h0 : ram_rdata;
    end
  end

  always_comb begin
    in_access = (state_q == StAccess);
    in_resp   = (state_q == StResp);
    a_gnt     = gnt_a;
    b_gnt     = gnt_b;
    ram_we    = in_access && we_q;
    ram_re    = in_access && !we_q;
    ram_addr  = in_access ? addr_q : '0;
    ram_wdata = in_access ? wdata_q : 32'h0;
    a_rvalid  = in_resp && !owner_q;
    b_rvalid  = in_resp && owner_q;
    a_rdata   = a_rvalid ? rdata_q : 32'h0;
    b_rdata   = b_rvalid ? rdata_q : 32'h0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1024-word RAM attached.
module tb_ram_arbiter;

  logic        CLK, RST_N;
  logic        a_req, a_we, b_req, b_we;
  logic [9:0]  a_addr, b_addr, ram_addr;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_wdata, ram_rdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, ram_re;
  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  ram_arbiter #(.ADDR_W(10)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle_inputs;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    RST_N = 0;
    tick();
    tick();
    RST_N = 1;
  endtask

  task automatic test_reset;
    RST_N = 0;
    a_req = 1; b_req = 1; a_we = 1; b_we = 1; a_addr = 10'h3; b_addr = 10'h4;
    tick();
    settle();
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL rst_gnt: got %b expected 00", {a_gnt, b_gnt});
    end
    n_checks++;
    if ({a_rvalid, b_rvalid, ram_we, ram_re} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_ctl: got %b expected 0000", {a_rvalid, b_rvalid, ram_we, ram_re});
    end
    n_checks++;
    if ({ram_addr, ram_wdata, a_rdata, b_rdata} !== '0) begin
      n_fail++;
      $display("FAIL rst_data: addr=%h wdata=%h ardata=%h brdata=%h expected all 0",
               ram_addr, ram_wdata, a_rdata, b_rdata);
    end
    idle_inputs();
    tick();
    RST_N = 1;
    settle();
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL idle_nogrant: got %b expected 00", {a_gnt, b_gnt});
    end
    tick();
  endtask

  // Both requesters read continuously; grants alternate starting with A.
  task automatic test_alternate;
    logic [3:0]  exp_ctl;
    logic [31:0] exp_ard, exp_brd;
    logic [9:0]  exp_addr;
    int          k;
    do_reset();
    a_req = 1; b_req = 1; a_we = 0; b_we = 0; a_addr = 10'd10; b_addr = 10'd20;
    for (int i = 0; i < 16; i++) begin
      settle();
      k = i / 2;
      exp_ctl = 4'b0000;
      if (i % 2 == 0) begin
        exp_ctl[3] = (k % 2 == 0);
        exp_ctl[2] = (k % 2 == 1);
        if (i >= 2) begin
          exp_ctl[1] = ((k - 1) % 2 == 0);
          exp_ctl[0] = ((k - 1) % 2 == 1);
        end
      end
      exp_ard  = exp_ctl[1] ? 32'h1111_0010 : 32'h0;
      exp_brd  = exp_ctl[0] ? 32'h2222_0020 : 32'h0;
      exp_addr = (i % 2 == 1) ? ((k % 2 == 0) ? 10'd10 : 10'd20) : 10'd0;
      n_checks++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== exp_ctl) begin
        n_fail++;
        $display("FAIL alt_ctl[%0d]: gnt/rvalid got %b expected %b", i,
                 {a_gnt, b_gnt, a_rvalid, b_rvalid}, exp_ctl);
      end
      n_checks++;
      if (a_rdata !== exp_ard || b_rdata !== exp_brd || ram_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL alt_data[%0d]: a=%h b=%h addr=%0d expected a=%h b=%h addr=%0d", i,
                 a_rdata, b_rdata, ram_addr, exp_ard, exp_brd, exp_addr);
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_write_read;
    a_req = 1; a_we = 1; a_addr = 10'd5; a_wdata = 32'hDEAD_BEEF;
    settle();
    n_checks++;
    if ({a_gnt, b_gnt, ram_we} !== 3'b100) begin
      n_fail++; $display("FAIL wr_gnt: got %b expected 100", {a_gnt, b_gnt, ram_we});
    end
    tick();
    idle_inputs();
    settle();
    n_checks++;
    if ({ram_we, ram_re, a_gnt} !== 3'b100 || ram_addr !== 10'd5 ||
        ram_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wr_access: we/re/gnt=%b addr=%0d wdata=%h expected 100 5 deadbeef",
               {ram_we, ram_re, a_gnt}, ram_addr, ram_wdata);
    end
    tick();
    a_req = 1; a_we = 0; a_addr = 10'd5;
    settle();
    n_checks++;
    if ({a_rvalid, a_gnt, ram_we} !== 3'b110 || a_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_resp: rvalid/gnt/we=%b rdata=%h expected 110 00000000",
               {a_rvalid, a_gnt, ram_we}, a_rdata);
    end
    tick();
    idle_inputs();
    settle();
    n_checks++;
    if ({ram_we, ram_re} !== 2'b01 || ram_addr !== 10'd5 || a_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_access: we/re=%b addr=%0d rvalid=%b expected 01 5 0",
               {ram_we, ram_re}, ram_addr, a_rvalid);
    end
    tick();
    settle();
    n_checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF || b_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_resp: a_rvalid=%b a_rdata=%h b_rvalid=%b expected 1 deadbeef 0",
               a_rvalid, a_rdata, b_rvalid);
    end
    tick();
  endtask

  task automatic test_max_addr;
    b_req = 1; b_we = 0; b_addr = 10'd1023;
    settle();
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL max_gnt: got %b expected 01", {a_gnt, b_gnt});
    end
    tick();
    idle_inputs();
    settle();
    n_checks++;
    if (ram_addr !== 10'd1023 || ram_re !== 1'b1) begin
      n_fail++; $display("FAIL max_addr: addr=%0d re=%b expected 1023 1", ram_addr, ram_re);
    end
    tick();
    settle();
    n_checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'hCAFE_F00D || a_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL max_resp: b_rvalid=%b b_rdata=%h a_rdata=%h expected 1 cafef00d 0",
               b_rvalid, b_rdata, a_rdata);
    end
    tick();
  endtask

  task automatic test_access_wait;
    a_req = 1; a_we = 0; a_addr = 10'd5;
    settle();
    tick();
    a_req = 0;
    b_req = 1; b_we = 0; b_addr = 10'd7;
    settle();
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL wait_access: gnt got %b expected 00", {a_gnt, b_gnt});
    end
    tick();
    settle();
    n_checks++;
    if ({b_gnt, a_rvalid} !== 2'b11 || a_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wait_resp: b_gnt/a_rvalid=%b a_rdata=%h expected 11 deadbeef",
               {b_gnt, a_rvalid}, a_rdata);
    end
    tick();
    idle_inputs();
    tick();
    settle();
    n_checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h0707_0707) begin
      n_fail++;
      $display("FAIL wait_b_resp: b_rvalid=%b b_rdata=%h expected 1 07070707",
               b_rvalid, b_rdata);
    end
    tick();
  endtask

  task automatic test_reset_in_access;
    b_req = 1; b_we = 1; b_addr = 10'd9; b_wdata = 32'h1234_5678;
    settle();
    tick();
    idle_inputs();
    settle();
    n_checks++;
    if (ram_we !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre: ram_we=%b expected 1", ram_we);
    end
    RST_N = 0;
    #1;
    n_checks++;
    if ({ram_we, ram_re} !== 2'b00 || ram_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL abort_drop: we/re=%b addr=%0d expected 00 0", {ram_we, ram_re}, ram_addr);
    end
    tick();
    n_checks++;
    if (mem[9] !== 32'hAAAA_5555) begin
      n_fail++; $display("FAIL abort_nowrite: mem[9]=%h expected aaaa5555", mem[9]);
    end
    tick();
    RST_N = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if ({a_rvalid, b_rvalid} !== 2'b00) begin
        n_fail++;
        $display("FAIL abort_norv[%0d]: rvalid got %b expected 00", i, {a_rvalid, b_rvalid});
      end
      tick();
    end
    a_req = 1; b_req = 1; a_addr = 10'd10; b_addr = 10'd20;
    settle();
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL abort_tie: gnt got %b expected 10", {a_gnt, b_gnt});
    end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[7]    = 32'h0707_0707;
    mem[9]    = 32'hAAAA_5555;
    mem[10]   = 32'h1111_0010;
    mem[20]   = 32'h2222_0020;
    mem[1023] = 32'hCAFE_F00D;
    idle_inputs();
    RST_N = 0;
    test_reset();
    test_alternate();
    test_write_read();
    test_max_addr();
    test_access_wait();
    test_reset_in_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
